// File: rtl/ltsm_sb_pkg.sv
// Shared sideband definitions for the LTSM handshake blocks: message codes,
// default timeout and the handshake FSM state encoding.
package ltsm_sb_pkg;

   localparam int SB_MSG_W = 4;

   localparam logic [SB_MSG_W-1:0] SB_MSG_NONE              = 4'd0;
   localparam logic [SB_MSG_W-1:0] SB_TRAINERROR_ENTRY_REQ  = 4'd15;
   localparam logic [SB_MSG_W-1:0] SB_TRAINERROR_ENTRY_RESP = 4'd14;
   localparam logic [SB_MSG_W-1:0] SB_STEP2_REQ             = 4'd13;
   localparam logic [SB_MSG_W-1:0] SB_STEP2_RESP            = 4'd12;

   // 8 ms at 100 MHz
   localparam int DEFAULT_TIMEOUT_CYCLES = 800000;
   localparam int DEFAULT_TO_CNT_W       = 20;

   typedef enum logic [2:0] {
      HS_IDLE,
      HS_WAIT_REQ,
      HS_PEND,
      HS_SEND,
      HS_DONE,
      HS_TIMEOUT
   } hs_state_e;

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// Saturating per-step timeout counter shared by the RX and TX handshakes.
// expired is asserted while the count sits at MAX-1.
module ltsm_timeout_cnt #(
   parameter int MAX   = 800000,
   parameter int WIDTH = 20
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic run,
   output logic expired
);

   logic [WIDTH-1:0] cnt;

   generate
      if (MAX < 1 || longint'(MAX) >= (longint'(1) << WIDTH)) begin : g_bad_max
         $error("ltsm_timeout_cnt: MAX must be >= 1 and MAX-1 must fit in WIDTH bits");
      end
   endgenerate

   assign expired = (cnt == WIDTH'(MAX - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of block evaluation order.
   always_ff @(posedge i_clk) begin
      if (i_rst || clr) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ltsm_rx_hs_responder.sv
// RX-side sideband handshake responder: answers each expected partner request
// with its paired response, deferring while local TX owns the sideband.
module ltsm_rx_hs_responder
   import ltsm_sb_pkg::*;
#(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int NUM_STEPS      = 2,
   parameter logic [NUM_STEPS*SB_MSG_WIDTH-1:0] REQ_MSGS = {4'd13, 4'd15},
   parameter logic [NUM_STEPS*SB_MSG_WIDTH-1:0] RSP_MSGS = {4'd12, 4'd14},
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TO_CNT_W       = DEFAULT_TO_CNT_W
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_rx_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
   input  logic                    i_SB_Busy,
   input  logic                    i_falling_edge_busy,
   input  logic                    i_tx_valid,
   output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
   output logic                    o_valid_rx,
   output logic                    o_end_rx,
   output logic                    o_timeout_rx,
   output logic [2:0]              o_step_idx
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_STEPS - 1);

   generate
      if (NUM_STEPS < 1 || NUM_STEPS > 8) begin : g_bad_steps
         $error("ltsm_rx_hs_responder: NUM_STEPS must be in 1..8");
      end
      if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TO_CNT_W)) begin : g_bad_to_w
         $error("ltsm_rx_hs_responder: TIMEOUT_CYCLES must be < 2**TO_CNT_W");
      end
   endgenerate

   hs_state_e               state;
   logic [SB_MSG_WIDTH-1:0] req_code;
   logic [SB_MSG_WIDTH-1:0] rsp_code;
   logic                    req_hit;
   logic                    bus_free;
   logic                    step_done;
   logic                    to_clr;
   logic                    to_run;
   logic                    to_expired;

   // NOTE: every always_comb output gets a value on every path, so no latch
   // can be inferred; idx never exceeds NUM_STEPS-1, keeping the selects in range.
   always_comb begin
      req_code = REQ_MSGS[32'(o_step_idx)*SB_MSG_WIDTH +: SB_MSG_WIDTH];
      rsp_code = RSP_MSGS[32'(o_step_idx)*SB_MSG_WIDTH +: SB_MSG_WIDTH];
   end

   assign req_hit   = (state == HS_WAIT_REQ) && i_rx_msg_valid && (i_decoded_SB_msg == req_code);
   assign bus_free  = !i_tx_valid && !i_SB_Busy;
   // The busy falling edge belongs to us only while our response is on the bus.
   assign step_done = (state == HS_SEND) && o_valid_rx && i_falling_edge_busy;

   // A matched request restarts the budget, so a match on the expiry edge wins.
   assign to_clr = !i_en || (state == HS_IDLE) || req_hit || step_done;
   assign to_run = (state == HS_WAIT_REQ) || (state == HS_PEND) || (state == HS_SEND);

   ltsm_timeout_cnt #(
      .MAX   (TIMEOUT_CYCLES),
      .WIDTH (TO_CNT_W)
   ) u_to_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .clr     (to_clr),
      .run     (to_run),
      .expired (to_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         state               <= HS_IDLE;
         o_step_idx          <= '0;
         o_encoded_SB_msg_rx <= '0;
         o_valid_rx          <= 1'b0;
         o_end_rx            <= 1'b0;
         o_timeout_rx        <= 1'b0;
      end else begin
         case (state)
            HS_IDLE: begin
               o_step_idx          <= '0;
               o_encoded_SB_msg_rx <= '0;
               o_valid_rx          <= 1'b0;
               o_end_rx            <= 1'b0;
               o_timeout_rx        <= 1'b0;
               state               <= HS_WAIT_REQ;
            end
            HS_WAIT_REQ: begin
               if (req_hit) begin
                  o_encoded_SB_msg_rx <= rsp_code;
                  state               <= HS_PEND;
               end else if (to_expired) begin
                  o_timeout_rx <= 1'b1;
                  state        <= HS_TIMEOUT;
               end
            end
            HS_PEND: begin
               if (bus_free) begin
                  o_valid_rx <= 1'b1;
                  state      <= HS_SEND;
               end else if (to_expired) begin
                  o_timeout_rx <= 1'b1;
                  state        <= HS_TIMEOUT;
               end
            end
            HS_SEND: begin
               if (step_done) begin
                  o_valid_rx <= 1'b0;
                  if (o_step_idx == LAST_IDX) begin
                     o_end_rx <= 1'b1;
                     state    <= HS_DONE;
                  end else begin
                     o_step_idx <= o_step_idx + 3'd1;
                     state      <= HS_WAIT_REQ;
                  end
               end else if (to_expired) begin
                  o_valid_rx   <= 1'b0;
                  o_timeout_rx <= 1'b1;
                  state        <= HS_TIMEOUT;
               end
            end
            HS_DONE: begin
               o_end_rx <= 1'b1;
            end
            HS_TIMEOUT: begin
               o_valid_rx   <= 1'b0;
               o_timeout_rx <= 1'b1;
            end
            default: begin
               state <= HS_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ltsm_rx_hs_responder.sv
// Directed bench for ltsm_rx_hs_responder: default-parameter instance for the
// handshake scenarios plus a short-timeout instance for expiry behaviour.
module tb_ltsm_rx_hs_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rx_valid;
   logic [3:0] dec_msg;
   logic       sb_busy;
   logic       fe_busy;
   logic       tx_valid;

   logic [3:0] msg,    msg_to;
   logic       valid,  valid_to;
   logic       end_rx, end_to;
   logic       to_rx,  to_to;
   logic [2:0] idx,    idx_to;

   int cmp = 0;
   int mis = 0;

   logic [10:0] exp_v;
   wire  [10:0] obs    = {valid, end_rx, to_rx, idx, msg};
   wire  [10:0] obs_to = {valid_to, end_to, to_to, idx_to, msg_to};

   always #5 clk = ~clk;

   ltsm_rx_hs_responder dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_en                (en),
      .i_rx_msg_valid      (rx_valid),
      .i_decoded_SB_msg    (dec_msg),
      .i_SB_Busy           (sb_busy),
      .i_falling_edge_busy (fe_busy),
      .i_tx_valid          (tx_valid),
      .o_encoded_SB_msg_rx (msg),
      .o_valid_rx          (valid),
      .o_end_rx            (end_rx),
      .o_timeout_rx        (to_rx),
      .o_step_idx          (idx)
   );

   ltsm_rx_hs_responder #(
      .TIMEOUT_CYCLES (50),
      .TO_CNT_W       (6)
   ) dut_to (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_en                (en),
      .i_rx_msg_valid      (rx_valid),
      .i_decoded_SB_msg    (dec_msg),
      .i_SB_Busy           (sb_busy),
      .i_falling_edge_busy (fe_busy),
      .i_tx_valid          (tx_valid),
      .o_encoded_SB_msg_rx (msg_to),
      .o_valid_rx          (valid_to),
      .o_end_rx            (end_to),
      .o_timeout_rx        (to_to),
      .o_step_idx          (idx_to)
   );

   // Expected output vector {valid, end, timeout, idx, msg}
   function automatic logic [10:0] ex(input logic v, input logic e, input logic t,
                                      input logic [2:0] i, input logic [3:0] m);
      return {v, e, t, i, m};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [3:0] code);
      rx_valid = 1'b1;
      dec_msg  = code;
      tick();
      rx_valid = 1'b0;
      dec_msg  = 4'd0;
   endtask

   task automatic pulse_fe();
      fe_busy = 1'b1;
      tick();
      fe_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; rx_valid = 1'b0; dec_msg = 4'd0;
      sb_busy = 1'b0; fe_busy = 1'b0; tx_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL reset_outputs: got %h want %h", obs, exp_v); end
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL reset_outputs_to: got %h want %h", obs_to, exp_v); end
   endtask

   task automatic test_basic();
      en = 1'b1; tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_wait_entry: got %h want %h", obs, exp_v); end
      send_req(4'd15);
      exp_v = ex(0, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_req_edge: got %h want %h", obs, exp_v); end
      tick();
      exp_v = ex(1, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_valid_rise: got %h want %h", obs, exp_v); end
      sb_busy = 1'b1; tick(); tick();
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_valid_hold: got %h want %h", obs, exp_v); end
      sb_busy = 1'b0; pulse_fe();
      exp_v = ex(0, 0, 0, 3'd1, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_step0_done: got %h want %h", obs, exp_v); end
      send_req(4'd13);
      exp_v = ex(0, 0, 0, 3'd1, 4'd12);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_req2_edge: got %h want %h", obs, exp_v); end
      tick();
      exp_v = ex(1, 0, 0, 3'd1, 4'd12);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_valid2_rise: got %h want %h", obs, exp_v); end
      pulse_fe();
      exp_v = ex(0, 1, 0, 3'd1, 4'd12);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_end: got %h want %h", obs, exp_v); end
      tick(); tick(); tick();
      send_req(4'd15);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_done_ignores_req: got %h want %h", obs, exp_v); end
      en = 1'b0; tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t1_end_clear: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_contention();
      en = 1'b1; tick();
      tx_valid = 1'b1; sb_busy = 1'b1;
      send_req(4'd15);
      exp_v = ex(0, 0, 0, 3'd0, 4'd14);
      repeat (4) tick();
      pulse_fe();
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t2_tx_fe_ignored: got %h want %h", obs, exp_v); end
      repeat (4) tick();
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t2_deferred: got %h want %h", obs, exp_v); end
      tx_valid = 1'b0; tick();
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t2_busy_still_defers: got %h want %h", obs, exp_v); end
      sb_busy = 1'b0; tick();
      exp_v = ex(1, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t2_valid_after_release: got %h want %h", obs, exp_v); end
      pulse_fe();
      exp_v = ex(0, 0, 0, 3'd1, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t2_step_advance: got %h want %h", obs, exp_v); end
      en = 1'b0; tick();
   endtask

   task automatic test_wrong_order();
      en = 1'b1; tick();
      send_req(4'd13);
      tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t3_wrong_req_ignored: got %h want %h", obs, exp_v); end
      send_req(4'd15);
      tick();
      exp_v = ex(1, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t3_right_req: got %h want %h", obs, exp_v); end
      en = 1'b0; tick();
   endtask

   task automatic test_abort();
      en = 1'b1; tick();
      send_req(4'd15); tick(); pulse_fe();
      send_req(4'd13); tick();
      exp_v = ex(1, 0, 0, 3'd1, 4'd12);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t5_in_send: got %h want %h", obs, exp_v); end
      en = 1'b0; tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t5_abort: got %h want %h", obs, exp_v); end
      en = 1'b1; tick();
      send_req(4'd13);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t5_restart_ignores_step1: got %h want %h", obs, exp_v); end
      send_req(4'd15);
      exp_v = ex(0, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t5_restart_step0: got %h want %h", obs, exp_v); end
      en = 1'b0; tick();
   endtask

   task automatic test_reset_mid();
      en = 1'b1; tick();
      tx_valid = 1'b1;
      send_req(4'd15); tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t6_pend: got %h want %h", obs, exp_v); end
      rst = 1'b1; tick(); rst = 1'b0;
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t6_reset_mid_pend: got %h want %h", obs, exp_v); end
      tx_valid = 1'b0; tick();
      send_req(4'd15); tick(); pulse_fe();
      send_req(4'd13); tick();
      fe_busy = 1'b1; en = 1'b0; tick(); fe_busy = 1'b0;
      cmp++; if (obs !== exp_v) begin mis++; $display("FAIL t6_fe_with_abort: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_timeout();
      logic saw_valid;
      saw_valid = 1'b0;
      en = 1'b0; tick();
      en = 1'b1; tick();
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (valid_to) saw_valid = 1'b1;
         if (i == 49) begin
            cmp++; if (to_to !== 1'b0) begin mis++; $display("FAIL t4_early_timeout: got %0b want 0", to_to); end
         end
      end
      exp_v = ex(0, 0, 1, 3'd0, 4'd0);
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL t4_timeout_at_50: got %h want %h", obs_to, exp_v); end
      cmp++; if (saw_valid !== 1'b0) begin mis++; $display("FAIL t4_valid_rose: got %0b want 0", saw_valid); end
      repeat (3) tick();
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL t4_timeout_held: got %h want %h", obs_to, exp_v); end
      en = 1'b0; tick();
      exp_v = ex(0, 0, 0, 3'd0, 4'd0);
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL t4_timeout_clear: got %h want %h", obs_to, exp_v); end
      // Request landing on the expiry edge must win and restart the budget
      en = 1'b1; tick();
      repeat (49) tick();
      send_req(4'd15);
      exp_v = ex(0, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL t4_match_beats_expiry: got %h want %h", obs_to, exp_v); end
      sb_busy = 1'b0; tick();
      repeat (40) tick();
      exp_v = ex(1, 0, 0, 3'd0, 4'd14);
      cmp++; if (obs_to !== exp_v) begin mis++; $display("FAIL t4_counter_restarted: got %h want %h", obs_to, exp_v); end
      en = 1'b0; tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_contention();
      test_wrong_order();
      test_abort();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule
